// File: rtl/cae_csr_bank.sv
// cae_csr_bank: parametrised CAE CSR bank with scratch registers, W1C errors with a maskable irq, and a registered read path.
// Event counters and CNT_CTL exist only when CAE_CSR_BANK_CNT_EN is defined.
module cae_csr_bank #(
  parameter int          NUM_SCRATCH = 4,
  parameter int          NUM_ERR     = 8,
  parameter int          NUM_CNT     = 4,
  parameter int          CNT_W       = 48,
  parameter logic [11:0] THLD_RST    = 12'd1536,
  parameter logic [63:0] VERSION     = 64'h0000_0000_0002_0000
) (
  input  logic                      clk_csr,
  input  logic                      i_csr_reset_n,
  input  logic                      func_wr_valid,
  input  logic                      func_rd_valid,
  input  logic [15:0]               func_address,
  input  logic [63:0]               func_wr_data,
  output logic                      func_ack,
  output logic [63:0]               func_rd_data,
  input  logic [63:0]               cae_csr_status,
  input  logic [NUM_ERR-1:0]        err_in,
  input  logic [NUM_CNT-1:0]        cnt_inc,
  output logic [NUM_SCRATCH*64-1:0] csr_scratch,
  output logic [11:0]               csr_ldst_thld,
  output logic                      csr_err_irq
);
  logic [63:0]        scratch_q [NUM_SCRATCH];
  logic [NUM_ERR-1:0] err_q, err_d, mask_q, mask_d;
  logic [11:0]        thld_q;
  logic [63:0]        cnt_rd, rd_mux;
  logic               wr_err, wr_mask;
  assign wr_err  = func_wr_valid && func_address == 16'h0002;
  assign wr_mask = func_wr_valid && func_address == 16'h0003;
  // a new error pulse wins over a simultaneous W1C of the same bit
  assign err_d   = (err_q & ~(wr_err ? func_wr_data[NUM_ERR-1:0] : '0)) | err_in;
  assign mask_d  = wr_mask ? func_wr_data[NUM_ERR-1:0] : mask_q;
`ifdef CAE_CSR_BANK_CNT_EN
  localparam logic ID_CNT = 1'b1;
  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic             freeze_q, cnt_clr;
  assign cnt_clr = func_wr_valid && func_address == 16'h0005 && func_wr_data[1];
  always_ff @(posedge clk_csr or negedge i_csr_reset_n)
    if (!i_csr_reset_n) begin
      freeze_q <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      if (func_wr_valid && func_address == 16'h0005) freeze_q <= func_wr_data[0];
      for (int i = 0; i < NUM_CNT; i++)
        cnt_q[i] <= cnt_clr ? '0 : (cnt_inc[i] && !freeze_q && !(&cnt_q[i])) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end
  always_comb begin
    cnt_rd = (func_address == 16'h0005) ? 64'(freeze_q) : '0;
    for (int i = 0; i < NUM_CNT; i++)
      if (func_address == 16'(16 + i)) cnt_rd = 64'(cnt_q[i]);
  end
`else
  localparam logic ID_CNT = 1'b0;
  logic unused_cnt_inc;
  assign unused_cnt_inc = ^cnt_inc;
  assign cnt_rd = '0;
`endif
  always_comb begin
    rd_mux = cnt_rd;
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (func_address == 16'(32 + i)) rd_mux = scratch_q[i];
    case (func_address)
      16'h0000: rd_mux = {ID_CNT, VERSION[62:0]};
      16'h0001: rd_mux = cae_csr_status;
      16'h0002: rd_mux = 64'(err_q);
      16'h0003: rd_mux = 64'(mask_q);
      16'h0004: rd_mux = 64'(thld_q);
      default: ;
    endcase
  end
  always_ff @(posedge clk_csr or negedge i_csr_reset_n)
    if (!i_csr_reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
      err_q        <= '0;
      mask_q       <= '0;
      thld_q       <= THLD_RST;
      csr_err_irq  <= 1'b0;
      func_ack     <= 1'b0;
      func_rd_data <= '0;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (func_wr_valid && func_address == 16'(32 + i)) scratch_q[i] <= func_wr_data;
      if (func_wr_valid && func_address == 16'h0004) thld_q <= func_wr_data[11:0];
      err_q        <= err_d;
      mask_q       <= mask_d;
      csr_err_irq  <= |(err_d & mask_d);
      func_ack     <= func_rd_valid;
      func_rd_data <= func_rd_valid ? rd_mux : '0;
    end
  for (genvar g = 0; g < NUM_SCRATCH; g++) assign csr_scratch[64*g +: 64] = scratch_q[g];
  assign csr_ldst_thld = thld_q;
endmodule

// File: tb/tb_cae_csr_bank.sv
// tb_cae_csr_bank: directed and random CSR traffic against a behavioural register-map model.
module tb_cae_csr_bank;
  localparam int NS = 4, NE = 8, NC = 4, CW = 4;
  localparam logic [63:0] VER = 64'h0000_0000_0002_0000;
`ifdef CAE_CSR_BANK_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic clk_csr = 0, i_csr_reset_n = 0, func_wr_valid = 0, func_rd_valid = 0;
  logic [15:0] func_address = '0;
  logic [63:0] func_wr_data = '0, cae_csr_status = '0, func_rd_data;
  logic [NE-1:0] err_in = '0;
  logic [NC-1:0] cnt_inc = '0;
  logic func_ack, csr_err_irq;
  logic [NS*64-1:0] csr_scratch;
  logic [11:0] csr_ldst_thld;
  int n_tests = 0, n_fail = 0;
  logic [63:0] m_scr [NS];
  logic [NE-1:0] m_err, m_mask;
  logic [11:0] m_thld;
  int m_cnt [NC];
  bit m_frz, e_ack, e_irq;
  logic [63:0] e_rd;
  logic [15:0] addrs [20] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
                              16'h0010, 16'h0011, 16'h0013, 16'h0014, 16'h0015, 16'h0020, 16'h0021,
                              16'h0023, 16'h0024, 16'h002F, 16'h0102, 16'h8020, 16'h1004};

  always #5 clk_csr = ~clk_csr;

  cae_csr_bank #(.NUM_SCRATCH(NS), .NUM_ERR(NE), .NUM_CNT(NC), .CNT_W(CW)) dut (
    .clk_csr(clk_csr), .i_csr_reset_n(i_csr_reset_n), .func_wr_valid(func_wr_valid),
    .func_rd_valid(func_rd_valid), .func_address(func_address), .func_wr_data(func_wr_data),
    .func_ack(func_ack), .func_rd_data(func_rd_data), .cae_csr_status(cae_csr_status),
    .err_in(err_in), .cnt_inc(cnt_inc), .csr_scratch(csr_scratch),
    .csr_ldst_thld(csr_ldst_thld), .csr_err_irq(csr_err_irq));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mread(input logic [15:0] a);
    if (a == 16'h0000) return {CNT_ON, VER[62:0]};
    if (a == 16'h0001) return cae_csr_status;
    if (a == 16'h0002) return 64'(m_err);
    if (a == 16'h0003) return 64'(m_mask);
    if (a == 16'h0004) return 64'(m_thld);
    if (a == 16'h0005) return CNT_ON ? 64'(m_frz) : 64'd0;
    if (a >= 16'h0010 && a < 16'h0010 + NC) return CNT_ON ? 64'(m_cnt[a - 16]) : 64'd0;
    if (a >= 16'h0020 && a < 16'h0020 + NS) return m_scr[a - 32];
    return 64'd0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    m_err = '0; m_mask = '0; m_thld = 12'h600; m_frz = 0;
    e_ack = 0; e_rd = '0; e_irq = 0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "/ack"}, 64'(func_ack), 64'(e_ack));
    check({tag, "/rd_data"}, func_rd_data, e_rd);
    check({tag, "/thld"}, 64'(csr_ldst_thld), 64'(m_thld));
    check({tag, "/irq"}, 64'(csr_err_irq), 64'(e_irq));
    for (int i = 0; i < NS; i++) check($sformatf("%s/scratch%0d", tag, i), csr_scratch[64*i +: 64], m_scr[i]);
  endtask

  task automatic step(input bit wv, input bit rv, input logic [15:0] a, input logic [63:0] d,
                      input logic [NE-1:0] e, input logic [NC-1:0] ci);
    bit clr;
    func_wr_valid = wv; func_rd_valid = rv; func_address = a; func_wr_data = d;
    err_in = e; cnt_inc = ci; cae_csr_status = {$urandom, $urandom};
    e_ack = rv;
    e_rd = rv ? mread(a) : 64'd0;
    clr = CNT_ON && wv && a == 16'h0005 && d[1];
    if (wv && a == 16'h0002) m_err = m_err & ~d[NE-1:0];
    m_err = m_err | e;
    if (wv && a == 16'h0003) m_mask = d[NE-1:0];
    if (wv && a == 16'h0004) m_thld = d[11:0];
    if (wv && a >= 16'h0020 && a < 16'h0020 + NS) m_scr[a - 32] = d;
    for (int i = 0; i < NC; i++)
      if (clr) m_cnt[i] = 0;
      else if (CNT_ON && ci[i] && !m_frz && m_cnt[i] < 2**CW - 1) m_cnt[i] = m_cnt[i] + 1;
    if (CNT_ON && wv && a == 16'h0005) m_frz = d[0];
    e_irq = |(m_err & m_mask);
    @(posedge clk_csr); #1;
    check_outs($sformatf("%s@%h", wv ? (rv ? "rw" : "wr") : (rv ? "rd" : "idle"), a));
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 64'h0, '0, '0);
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clk_csr);
    #1;
    check_outs("reset");
    @(negedge clk_csr) i_csr_reset_n = 1;

    step(0, 1, 16'h0004, 64'h0, '0, '0);
    check("thld_read", func_rd_data, 64'h600);
    idle();
    check("ack_one_cycle", 64'(func_ack), 64'd0);

    step(1, 0, 16'h0022, 64'hDEADBEEF_01234567, '0, '0);
    step(0, 1, 16'h0022, 64'h0, '0, '0);
    check("scratch2_read", func_rd_data, 64'hDEADBEEF_01234567);
    check("scratch2_out", csr_scratch[191:128], 64'hDEADBEEF_01234567);
    step(0, 1, 16'h0020 + NS, 64'h0, '0, '0);
    check("scratch_oob_ack", 64'(func_ack), 64'd1);
    check("scratch_oob_data", func_rd_data, 64'd0);
    step(1, 1, 16'h0021, 64'h1111_2222_3333_4444, '0, '0);
    check("rw_same_old", func_rd_data, 64'd0);

    step(1, 0, 16'h0003, 64'h8, '0, '0);
    step(0, 0, 16'h0, 64'h0, 8'h08, '0);
    check("err_irq_set", 64'(csr_err_irq), 64'd1);
    step(0, 1, 16'h0002, 64'h0, '0, '0);
    check("err_read", func_rd_data, 64'h8);
    step(1, 0, 16'h0002, 64'h8, 8'h08, '0);
    step(0, 1, 16'h0002, 64'h0, '0, '0);
    check("err_set_wins", func_rd_data, 64'h8);
    step(1, 0, 16'h0002, 64'h8, '0, '0);
    check("err_irq_clr", 64'(csr_err_irq), 64'd0);
    step(0, 1, 16'h0002, 64'h0, '0, '0);
    check("err_cleared", func_rd_data, 64'h0);

    step(0, 1, 16'h0000, 64'h0, '0, '0);
    check("id_cnt_bit", 64'(func_rd_data[63]), 64'(CNT_ON));
`ifdef CAE_CSR_BANK_CNT_EN
    repeat (20) step(0, 0, 16'h0, 64'h0, '0, 4'b0010);
    step(0, 1, 16'h0011, 64'h0, '0, '0);
    check("cnt_saturate", func_rd_data, 64'hF);
    step(1, 0, 16'h0005, 64'h1, '0, '0);
    repeat (5) step(0, 0, 16'h0, 64'h0, '0, 4'b0011);
    step(0, 1, 16'h0011, 64'h0, '0, '0);
    check("cnt_frozen", func_rd_data, 64'hF);
    step(0, 1, 16'h0010, 64'h0, '0, '0);
    check("cnt0_frozen", func_rd_data, 64'h0);
    step(1, 0, 16'h0005, 64'h2, '0, 4'b0010);
    step(0, 1, 16'h0011, 64'h0, '0, '0);
    check("cnt_clear_wins", func_rd_data, 64'h0);
    repeat (3) step(0, 0, 16'h0, 64'h0, '0, 4'b0100);
    step(0, 1, 16'h0012, 64'h0, '0, 4'b0100);
    check("cnt_read_old", func_rd_data, 64'h3);
    step(1, 0, 16'h0005, 64'h3, '0, '0);
    step(0, 1, 16'h0012, 64'h0, '0, 4'b0100);
    check("cnt_w3_clear", func_rd_data, 64'h0);
    step(0, 1, 16'h0005, 64'h0, '0, '0);
    check("cnt_ctl_read", func_rd_data, 64'h1);
    step(1, 0, 16'h0005, 64'h0, '0, '0);
`else
    repeat (10) step(0, 0, 16'h0, 64'h0, '0, '1);
    step(1, 0, 16'h0005, 64'h1, '0, '0);
    step(0, 1, 16'h0010, 64'h0, '0, '1);
    check("nocnt_read", func_rd_data, 64'h0);
    step(0, 1, 16'h0005, 64'h0, '0, '0);
    check("nocnt_ctl", func_rd_data, 64'h0);
`endif

    step(1, 0, 16'h0003, 64'hFF, 8'h01, '0);
    step(1, 0, 16'h0004, 64'h123, '0, '0);
    step(0, 1, 16'h0022, 64'h0, '0, '0);
    check("pre_reset_ack", 64'(func_ack), 64'd1);
    i_csr_reset_n = 0;
    func_rd_valid = 0; func_wr_valid = 0; err_in = '0; cnt_inc = '0;
    m_reset();
    #1;
    check_outs("mid_reset");
    @(negedge clk_csr) i_csr_reset_n = 1;
    step(0, 1, 16'h0003, 64'h0, '0, '0);
    check("mask_after_reset", func_rd_data, 64'h0);

    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 19)];
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, {$urandom, $urandom},
           ($urandom_range(0, 4) == 0) ? NE'($urandom) : '0, NC'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
